// File: rtl/tcp_rx_parser.sv
// -----------------------------------------------------------------------------
// tcp_rx_parser
//
// Receive-path TCP parser sitting behind the IPv4 stage. One TCP segment per
// input packet, one byte per beat. The fixed 20-byte header is captured, TCP
// options are skipped, the checksum (seeded with the IPv4 pseudo-header sum)
// is verified, payload bytes are forwarded through a small FIFO and one
// metadata record is emitted per segment.
//
// Handshakes: every stream (s_axis, m_axis, meta) transfers on a rising edge
// where valid and ready are both 1. A source holds valid and its payload stable
// until the transfer; ready may change freely and never depends on valid.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_axis_*            input segment bytes (tdata/tvalid/tready/tlast)
//   ph_sum              pseudo-header one's-complement sum, taken on byte 0
//   filter_en/port      optional destination-port filter
//   m_axis_*            forwarded payload bytes (tdata/tvalid/tready/tlast)
//   meta_valid/ready    per-segment metadata handshake
//   meta_*              captured header fields, payload length, status bits
//   dbg_state           current parser state (S_HDR=0 .. S_META=4)
// -----------------------------------------------------------------------------
module tcp_rx_parser #(
    parameter int FIFO_DEPTH    = 64,
    parameter int PAYLOAD_LEN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [15:0]              ph_sum,
    input  logic                     filter_en,
    input  logic [15:0]              filter_port,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     meta_valid,
    input  logic                     meta_ready,
    output logic [15:0]              meta_src_port,
    output logic [15:0]              meta_dst_port,
    output logic [31:0]              meta_seq_num,
    output logic [31:0]              meta_ack_num,
    output logic [7:0]               meta_flags,
    output logic [15:0]              meta_window_size,
    output logic [PAYLOAD_LEN_W-1:0] meta_payload_len,
    output logic                     meta_csum_ok,
    output logic                     meta_dropped,
    output logic                     meta_err,
    output logic [2:0]               dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_OPT  = 3'd1,
        S_PAY  = 3'd2,
        S_FOLD = 3'd3,
        S_META = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Capture registers
    logic [5:0]               r_off;      // header/option byte offset
    logic                     r_odd;      // parity of the current segment offset
    logic [31:0]              r_acc;
    logic [15:0]              r_src;
    logic [15:0]              r_dst;
    logic [31:0]              r_seq;
    logic [31:0]              r_ack;
    logic [3:0]               r_do;
    logic [7:0]               r_flags;
    logic [15:0]              r_win;
    logic [PAYLOAD_LEN_W-1:0] r_pay_len;
    logic                     r_csum_ok;
    logic                     r_err;
    logic                     r_drop;

    // Payload FIFO: {tlast, tdata}; pointers carry one extra wrap bit
    logic [8:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    logic        w_full;
    logic        w_empty;
    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic        w_meta_hs;
    logic        w_err_nxt;
    logic        w_drop_nxt;
    logic [5:0]  w_hdr_end;
    logic [31:0] w_term;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;
    logic [8:0]  w_rd_word;

    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty   = (r_wptr == r_rptr);
    assign w_acc     = s_axis_tvalid & s_axis_tready;
    assign w_wr      = w_acc && (r_state == S_PAY) && !r_drop;
    assign w_rd      = m_axis_tvalid & m_axis_tready;
    assign w_meta_hs = (r_state == S_META) & meta_ready;

    // Last offset of the options area: 4*DO - 1
    assign w_hdr_end = {r_do, 2'b00} - 6'd1;

    // Even offsets are the high byte of a 16-bit word; an odd trailing byte
    // therefore ends up padded with a zero low byte automatically.
    assign w_term = r_odd ? {24'h0, s_axis_tdata} : {16'h0, s_axis_tdata, 8'h00};

    // Two end-around-carry folds; after the first the value is at most
    // 17'h1FFFE, so the second cannot carry out again.
    assign w_fold1 = {1'b0, r_acc[15:0]} + {1'b0, r_acc[31:16]};
    assign w_fold2 = w_fold1[15:0] + {15'h0, w_fold1[16]};

    // Input ready is held low during reset and while the segment is closing.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst) begin
            case (r_state)
                S_HDR, S_OPT: s_axis_tready = 1'b1;
                S_PAY:        s_axis_tready = r_drop | ~w_full;
                default:      s_axis_tready = 1'b0;
            endcase
        end
    end

    // Next-state logic; also decides err/drop for the segment.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_drop_nxt  = r_drop;
        case (r_state)
            S_HDR: begin
                if (w_acc) begin
                    if (r_off == 6'd19) begin
                        // Header ending on tlast is only legal without options
                        w_err_nxt  = (r_do < 4'd5) | (s_axis_tlast & (r_do > 4'd5));
                        w_drop_nxt = w_err_nxt | (filter_en & (r_dst != filter_port));
                        if (s_axis_tlast)
                            w_state_nxt = S_FOLD;
                        else if (r_do > 4'd5)
                            w_state_nxt = S_OPT;
                        else
                            w_state_nxt = S_PAY;
                    end else if (s_axis_tlast) begin
                        w_err_nxt   = 1'b1;
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = S_FOLD;
                    end
                end
            end
            S_OPT: begin
                if (w_acc) begin
                    if (r_off == w_hdr_end) begin
                        w_state_nxt = s_axis_tlast ? S_FOLD : S_PAY;
                    end else if (s_axis_tlast) begin
                        w_err_nxt   = 1'b1;
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = S_FOLD;
                    end
                end
            end
            S_PAY: begin
                if (w_acc && s_axis_tlast)
                    w_state_nxt = S_FOLD;
            end
            S_FOLD: w_state_nxt = S_META;
            S_META: begin
                if (meta_ready)
                    w_state_nxt = S_HDR;
            end
            default: w_state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_HDR;
        else
            r_state <= w_state_nxt;
    end

    // Header capture, checksum and counters. The metadata handshake clears
    // everything so the next segment starts from a clean slate.
    always_ff @(posedge clk) begin
        if (rst || w_meta_hs) begin
            r_off     <= 6'd0;
            r_odd     <= 1'b0;
            r_acc     <= 32'h0;
            r_src     <= 16'h0;
            r_dst     <= 16'h0;
            r_seq     <= 32'h0;
            r_ack     <= 32'h0;
            r_do      <= 4'h0;
            r_flags   <= 8'h0;
            r_win     <= 16'h0;
            r_pay_len <= '0;
            r_csum_ok <= 1'b0;
            r_err     <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_err  <= w_err_nxt;
            r_drop <= w_drop_nxt;
            if (w_acc) begin
                r_odd <= ~r_odd;
                // Byte 0 of the segment seeds the sum with the pseudo-header
                if (r_state == S_HDR && r_off == 6'd0)
                    r_acc <= {16'h0, ph_sum} + w_term;
                else
                    r_acc <= r_acc + w_term;
                if (r_state == S_HDR || r_state == S_OPT)
                    r_off <= r_off + 6'd1;
                if (r_state == S_HDR) begin
                    case (r_off)
                        6'd0:  r_src[15:8]   <= s_axis_tdata;
                        6'd1:  r_src[7:0]    <= s_axis_tdata;
                        6'd2:  r_dst[15:8]   <= s_axis_tdata;
                        6'd3:  r_dst[7:0]    <= s_axis_tdata;
                        6'd4:  r_seq[31:24]  <= s_axis_tdata;
                        6'd5:  r_seq[23:16]  <= s_axis_tdata;
                        6'd6:  r_seq[15:8]   <= s_axis_tdata;
                        6'd7:  r_seq[7:0]    <= s_axis_tdata;
                        6'd8:  r_ack[31:24]  <= s_axis_tdata;
                        6'd9:  r_ack[23:16]  <= s_axis_tdata;
                        6'd10: r_ack[15:8]   <= s_axis_tdata;
                        6'd11: r_ack[7:0]    <= s_axis_tdata;
                        6'd12: r_do          <= s_axis_tdata[7:4];
                        6'd13: r_flags       <= s_axis_tdata;
                        6'd14: r_win[15:8]   <= s_axis_tdata;
                        6'd15: r_win[7:0]    <= s_axis_tdata;
                        default: ;
                    endcase
                end
                if (r_state == S_PAY && r_pay_len != {PAYLOAD_LEN_W{1'b1}})
                    r_pay_len <= r_pay_len + {{(PAYLOAD_LEN_W-1){1'b0}}, 1'b1};
            end
            if (r_state == S_FOLD)
                r_csum_ok <= (w_fold2 == 16'hFFFF);
        end
    end

    // FIFO pointers; metadata handshake leaves them alone so payload of the
    // previous segment keeps draining while the next one is parsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_rd)
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    assign w_rd_word     = r_mem[r_rptr[AW-1:0]];
    assign m_axis_tvalid = ~w_empty;
    // Gate the data so an empty FIFO shows zeros instead of stale entries
    assign m_axis_tdata  = w_empty ? 8'h00 : w_rd_word[7:0];
    assign m_axis_tlast  = w_empty ? 1'b0  : w_rd_word[8];

    assign meta_valid       = (r_state == S_META);
    assign meta_src_port    = r_src;
    assign meta_dst_port    = r_dst;
    assign meta_seq_num     = r_seq;
    assign meta_ack_num     = r_ack;
    assign meta_flags       = r_flags;
    assign meta_window_size = r_win;
    assign meta_payload_len = r_pay_len;
    assign meta_csum_ok     = r_csum_ok;
    assign meta_dropped     = r_drop;
    assign meta_err         = r_err;
    assign dbg_state        = r_state;

endmodule

// File: doc/tcp_rx_parser.md
# tcp_rx_parser

Second-generation TCP receive parser, placed after the IPv4 stage in the receive path. It consumes one TCP segment per AXI4-Stream packet, one byte per beat. It extracts the full fixed header, skips TCP options, and verifies the TCP checksum, including the pseudo-header sum supplied by the IPv4 stage. An optional destination-port filter is available. Payload is forwarded through an internal FIFO with real backpressure, and a single metadata record is emitted per segment.

## Interface
Parameters:
- FIFO_DEPTH, 64: payload FIFO entries, each holding 8-bit data plus tlast. Must be a power of two, ≥4.
- PAYLOAD_LEN_W, 16: width of the payload byte counter. The counter saturates at all-ones.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  8  segment byte
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1  last byte of segment
- ph_sum  in  16  one's-complement pseudo-header sum (src IP, dst IP, proto, TCP length); sampled on the first accepted beat of a segment
- filter_en  in  1  enable destination-port filter
- filter_port  in  16  accepted destination port
- m_axis_tdata  out  8  payload byte
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- meta_valid  out  1
- meta_ready  in  1
- meta_src_port, meta_dst_port  out  16 each
- meta_seq_num, meta_ack_num  out  32 each
- meta_flags  out  8  byte 13 of the header (CWR..FIN)
- meta_window_size  out  16
- meta_payload_len  out  PAYLOAD_LEN_W
- meta_csum_ok  out  1  folded sum equals 16'hFFFF
- meta_dropped  out  1  payload was not forwarded (filter miss or error)
- meta_err  out  1  truncated segment, or data offset < 5

## Operation
- States:
  - S_HDR: bytes 0–19.
  - S_OPT: skip bytes 20 to 4·DO−1.
  - S_PAY: payload.
  - S_FOLD: one cycle.
  - S_META: hold until meta_ready.
- Header bytes are captured by byte offset, big-endian: ports 0–3, seq 4–7, ack 8–11, DO = byte 12[7:4], flags = byte 13, window 14–15. Checksum bytes 16–17 and urgent bytes 18–19 enter the sum only.
- At offset 19:
  - DO < 5 sets err; the rest of the segment is consumed and dropped.
  - Next state is S_OPT if DO > 5, otherwise S_PAY.
  - Drop decision: drop = err | (filter_en & dst_port ≠ filter_port).
- A header that ends exactly on tlast goes directly to S_FOLD with payload_len = 0.
- Every accepted byte enters the checksum:
  - Even offsets form the high byte, odd offsets the low byte.
  - The accumulator is 32-bit, initialised to ph_sum on the first beat.
  - An odd trailing byte is padded with 8'h00.
  - S_FOLD folds twice (add carries [31:16] into [15:0]).
- Payload bytes are written to the FIFO unless dropped. The FIFO tlast bit equals s_axis_tlast.
- Payload_len counts accepted S_PAY bytes whether or not they are dropped, saturating.
- tlast in S_HDR or S_OPT before the header is complete: err = 1, dropped = 1, go to S_FOLD.
- S_META drives all meta_* outputs from registers, stable while meta_valid = 1. The handshake returns the block to S_HDR and clears all capture registers.
- Metadata emission does not wait for the FIFO to drain. A new segment may be parsed while the previous payload is still draining.

## Timing
- s_axis_tready:
  - 1 in S_HDR/S_OPT.
  - In S_PAY it equals !fifo_full, or 1 when dropping.
  - 0 in S_FOLD/S_META.
- FIFO latency: a byte written at edge N is presented on m_axis at N+1. m_axis_tvalid = !empty. m_axis_tdata/tlast hold stable while tvalid & !tready.
- Simultaneous write and read when full: the write is refused, because tready was 0 that cycle. When empty, a read never occurs.
- Pointers carry an extra wrap bit. full = ptrs equal except MSB; empty = ptrs fully equal.
- Segment end timing: last byte accepted at edge N, S_FOLD at N, meta_valid = 1 from N+1. If meta_ready is held high, the minimum gap between segments is 2 idle cycles.
- Reset values: all outputs 0 (s_axis_tready = 0 during rst, 1 the cycle after). State S_HDR, FIFO empty. Reset mid-segment discards the FIFO contents and any partial metadata.

## Test plan
- Segment with DO = 5, no options, 6-byte payload "ABCDEF", valid checksum, m_axis_tready = 1 → bytes appear 1 cycle after acceptance, tlast on 'F'. Meta: payload_len = 6, csum_ok = 1, dropped = 0, err = 0.
- DO = 8 (12 option bytes) with odd 5-byte payload and correct checksum → options are not forwarded, payload_len = 5, csum_ok = 1. Corrupting one payload byte → csum_ok = 0, payload still forwarded.
- filter_en = 1, filter_port = 16'h0050, segment dst port 16'h1F90 with 10-byte payload → m_axis_tvalid stays 0, meta_dropped = 1, payload_len = 10.
- FIFO_DEPTH = 4, 10-byte payload, m_axis_tready held 0 → s_axis_tready falls after 4 payload bytes. Releasing tready then delivers all 10 bytes in order with no loss.
- tlast at header byte 11 → meta_err = 1, meta_dropped = 1, no m_axis beats. meta_ready held 0 for 5 cycles → meta fields stable and s_axis_tready = 0 throughout.
- rst asserted while in S_PAY with 3 bytes buffered → next cycle m_axis_tvalid = 0 and meta_valid = 0. A following clean segment parses correctly.
